// File: rtl/vec_fwd_hazard_unit.sv
// Vector operand forwarding and load-use hazard unit for the ID stage.
// Resolves both sources per lane against EX/MEM/WB and latches them into the ID/EX operand register.
module vec_fwd_hazard_unit #(
   parameter int LANES   = 4,
   parameter int LANE_W  = 32,
   parameter int RADDR_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [RADDR_W-1:0]        id_rs_a,
   input  logic [RADDR_W-1:0]        id_rs_b,
   input  logic                      id_imm_b,
   input  logic [LANES*LANE_W-1:0]   id_a_data,
   input  logic [LANES*LANE_W-1:0]   id_b_data,
   input  logic                      ex_valid,
   input  logic                      ex_we,
   input  logic                      ex_is_load,
   input  logic [RADDR_W-1:0]        ex_dest,
   input  logic [LANES-1:0]          ex_lmask,
   input  logic [LANES*LANE_W-1:0]   ex_res,
   input  logic                      mem_valid,
   input  logic                      mem_we,
   input  logic                      mem_is_load,
   input  logic                      mem_rdy,
   input  logic [RADDR_W-1:0]        mem_dest,
   input  logic [LANES-1:0]          mem_lmask,
   input  logic [LANES*LANE_W-1:0]   mem_res,
   input  logic                      wb_we,
   input  logic [RADDR_W-1:0]        wb_dest,
   input  logic [LANES-1:0]          wb_lmask,
   input  logic [LANES*LANE_W-1:0]   wb_res,
   input  logic                      cnt_clr,
   output logic                      stall_id,
   output logic [LANES*LANE_W-1:0]   opa_q,
   output logic [LANES*LANE_W-1:0]   opb_q,
   output logic                      op_valid_q,
   output logic [CNT_W-1:0]          stall_cnt
);

   localparam int VEC_W = LANES * LANE_W;

   typedef enum logic {RUN, LU_WAIT} state_t;

   state_t             state, state_nxt;
   logic               a_used, b_used;
   logic               ex_fwd, mem_fwd;
   logic               ex_ld, mem_ld_wait;
   logic               hz_ex, hz_mem;
   logic               stall_raw;
   logic [VEC_W-1:0]   opa_res, opb_res;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Register 0 is hard-wired zero; an immediate B never takes part in forwarding or hazards.
   assign a_used  = (id_rs_a != '0);
   assign b_used  = (id_rs_b != '0) && !id_imm_b;
   assign ex_fwd  = ex_valid && ex_we && !ex_is_load;
   assign mem_fwd = mem_valid && mem_we && (!mem_is_load || mem_rdy);

   always_comb begin
      opa_res = id_a_data;
      opb_res = id_b_data;
      for (int l = 0; l < LANES; l++) begin
         if (a_used) begin
            if (ex_fwd && (ex_dest == id_rs_a) && ex_lmask[l])
               opa_res[l*LANE_W +: LANE_W] = ex_res[l*LANE_W +: LANE_W];
            else if (mem_fwd && (mem_dest == id_rs_a) && mem_lmask[l])
               opa_res[l*LANE_W +: LANE_W] = mem_res[l*LANE_W +: LANE_W];
            else if (wb_we && (wb_dest == id_rs_a) && wb_lmask[l])
               opa_res[l*LANE_W +: LANE_W] = wb_res[l*LANE_W +: LANE_W];
         end
         if (b_used) begin
            if (ex_fwd && (ex_dest == id_rs_b) && ex_lmask[l])
               opb_res[l*LANE_W +: LANE_W] = ex_res[l*LANE_W +: LANE_W];
            else if (mem_fwd && (mem_dest == id_rs_b) && mem_lmask[l])
               opb_res[l*LANE_W +: LANE_W] = mem_res[l*LANE_W +: LANE_W];
            else if (wb_we && (wb_dest == id_rs_b) && wb_lmask[l])
               opb_res[l*LANE_W +: LANE_W] = wb_res[l*LANE_W +: LANE_W];
         end
      end
   end

   assign ex_ld       = ex_valid && ex_we && ex_is_load && (ex_lmask != '0);
   assign mem_ld_wait = mem_valid && mem_we && mem_is_load && !mem_rdy && (mem_lmask != '0);

   assign hz_ex  = id_valid && ex_ld &&
                   ((a_used && (ex_dest == id_rs_a)) || (b_used && (ex_dest == id_rs_b)));
   assign hz_mem = id_valid && mem_ld_wait &&
                   ((a_used && (mem_dest == id_rs_a)) || (b_used && (mem_dest == id_rs_b)));

   always_comb begin
      state_nxt = state;
      stall_raw = 1'b0;
      case (state)
         RUN: begin
            stall_raw = hz_ex || hz_mem;
            if (hz_ex) state_nxt = LU_WAIT;
         end
         LU_WAIT: begin
            stall_raw = !mem_rdy;
            if (mem_rdy) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign stall_id = !rst && stall_raw;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // ID/EX operand latch: a stall inserts a bubble while keeping the last operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         opa_q      <= '0;
         opb_q      <= '0;
         op_valid_q <= 1'b0;
      end else if (stall_id) begin
         op_valid_q <= 1'b0;
      end else begin
         opa_q      <= opa_res;
         opb_q      <= opb_res;
         op_valid_q <= id_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) stall_cnt <= '0;
      else if (stall_id)  stall_cnt <= sat_inc(stall_cnt);
   end

endmodule

// File: tb/tb_vec_fwd_hazard_unit.sv
// Directed bench for vec_fwd_hazard_unit: per-cycle comparison against a behavioural model
// plus literal expectations for the forwarding, load-use, counter and reset scenarios.
module tb_vec_fwd_hazard_unit;

   localparam int LANES   = 4;
   localparam int LANE_W  = 32;
   localparam int RADDR_W = 4;
   localparam int CNT_W   = 4;
   localparam int VW      = LANES * LANE_W;

   logic               clk = 1'b0;
   logic               rst;
   logic               id_valid, id_imm_b;
   logic [RADDR_W-1:0] id_rs_a, id_rs_b;
   logic [VW-1:0]      id_a_data, id_b_data;
   logic               ex_valid, ex_we, ex_is_load;
   logic [RADDR_W-1:0] ex_dest;
   logic [LANES-1:0]   ex_lmask;
   logic [VW-1:0]      ex_res;
   logic               mem_valid, mem_we, mem_is_load, mem_rdy;
   logic [RADDR_W-1:0] mem_dest;
   logic [LANES-1:0]   mem_lmask;
   logic [VW-1:0]      mem_res;
   logic               wb_we;
   logic [RADDR_W-1:0] wb_dest;
   logic [LANES-1:0]   wb_lmask;
   logic [VW-1:0]      wb_res;
   logic               cnt_clr;
   logic               stall_id;
   logic [VW-1:0]      opa_q, opb_q;
   logic               op_valid_q;
   logic [CNT_W-1:0]   stall_cnt;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   vec_fwd_hazard_unit #(.LANES(LANES), .LANE_W(LANE_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_imm_b(id_imm_b),
      .id_a_data(id_a_data), .id_b_data(id_b_data),
      .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_dest(ex_dest),
      .ex_lmask(ex_lmask), .ex_res(ex_res),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_rdy(mem_rdy),
      .mem_dest(mem_dest), .mem_lmask(mem_lmask), .mem_res(mem_res),
      .wb_we(wb_we), .wb_dest(wb_dest), .wb_lmask(wb_lmask), .wb_res(wb_res),
      .cnt_clr(cnt_clr), .stall_id(stall_id),
      .opa_q(opa_q), .opb_q(opb_q), .op_valid_q(op_valid_q), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [VW-1:0]    m_opa = '0, m_opb = '0;
   bit               m_vld = 1'b0;
   int               m_cnt = 0;
   bit               m_load_pending = 1'b0;

   function automatic logic [VW-1:0] m_resolve(input logic [RADDR_W-1:0] s,
                                               input logic [VW-1:0] rf, input bit allow);
      logic [VW-1:0] r;
      r = rf;
      if (!allow || s == 0) return rf;
      for (int l = 0; l < LANES; l++) begin
         if (ex_valid && ex_we && !ex_is_load && ex_dest == s && ex_lmask[l])
            r[l*LANE_W +: LANE_W] = ex_res[l*LANE_W +: LANE_W];
         else if (mem_valid && mem_we && mem_dest == s && mem_lmask[l] && (!mem_is_load || mem_rdy))
            r[l*LANE_W +: LANE_W] = mem_res[l*LANE_W +: LANE_W];
         else if (wb_we && wb_dest == s && wb_lmask[l])
            r[l*LANE_W +: LANE_W] = wb_res[l*LANE_W +: LANE_W];
      end
      return r;
   endfunction

   function automatic bit m_reads(input logic [RADDR_W-1:0] d);
      return id_valid && d != 0 && (id_rs_a == d || (!id_imm_b && id_rs_b == d));
   endfunction

   function automatic bit m_ex_load_hit();
      return ex_valid && ex_we && ex_is_load && ex_lmask != 0 && m_reads(ex_dest);
   endfunction

   function automatic bit m_stall();
      if (rst) return 1'b0;
      if (m_load_pending) return !mem_rdy;
      return m_ex_load_hit() ||
             (mem_valid && mem_we && mem_is_load && !mem_rdy && mem_lmask != 0 && m_reads(mem_dest));
   endfunction

   always @(posedge clk) begin
      bit st;
      if (rst) begin
         m_opa = '0; m_opb = '0; m_vld = 1'b0; m_cnt = 0; m_load_pending = 1'b0;
      end else begin
         st = m_stall();
         if (st) m_vld = 1'b0;
         else begin
            m_opa = m_resolve(id_rs_a, id_a_data, 1'b1);
            m_opb = m_resolve(id_rs_b, id_b_data, !id_imm_b);
            m_vld = id_valid;
         end
         if (cnt_clr) m_cnt = 0;
         else if (st && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
         m_load_pending = m_load_pending ? !mem_rdy : m_ex_load_hit();
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_stall_id",   VW'(stall_id),   VW'(m_stall()));
         chk("cmp_opa_q",      opa_q,           m_opa);
         chk("cmp_opb_q",      opb_q,           m_opb);
         chk("cmp_op_valid_q", VW'(op_valid_q), VW'(m_vld));
         chk("cmp_stall_cnt",  VW'(stall_cnt),  VW'(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_imm_b = 0; id_rs_a = 0; id_rs_b = 0;
      id_a_data = {4{32'h0000_DEAD}}; id_b_data = {4{32'h0000_BEEF}};
      ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_dest = 0; ex_lmask = 0; ex_res = '0;
      mem_valid = 0; mem_we = 0; mem_is_load = 0; mem_rdy = 0; mem_dest = 0; mem_lmask = 0;
      mem_res = '0; wb_we = 0; wb_dest = 0; wb_lmask = 0; wb_res = '0; cnt_clr = 0;
   endtask

   task automatic ex_alu(input logic [RADDR_W-1:0] d, input logic [LANES-1:0] m, input logic [VW-1:0] r);
      ex_valid = 1; ex_we = 1; ex_is_load = 0; ex_dest = d; ex_lmask = m; ex_res = r;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick(); tick();
      chk("rst_stall_id", VW'(stall_id), '0);
      chk("rst_opa_q", opa_q, '0);
      chk("rst_op_valid_q", VW'(op_valid_q), '0);
      chk("rst_stall_cnt", VW'(stall_cnt), '0);
      rst = 0;
      chk_en = 1;

      // EX forward, full mask
      id_valid = 1; id_rs_a = 3; id_rs_b = 1;
      ex_alu(3, 4'b1111, {4{32'h11}});
      #1 chk("nohz_stall", VW'(stall_id), '0);
      tick();
      chk("nohz_opa", opa_q, {4{32'h11}});
      chk("nohz_opb", opb_q, {4{32'h0000_BEEF}});

      // EX has priority on lane 0, MEM supplies the rest
      idle_inputs(); id_valid = 1; id_rs_a = 5;
      ex_alu(5, 4'b0001, {4{32'hA}});
      mem_valid = 1; mem_we = 1; mem_dest = 5; mem_lmask = 4'b1111; mem_res = {4{32'hB}};
      tick();
      chk("prio_opa", opa_q, {32'hB, 32'hB, 32'hB, 32'hA});

      // lane fall-through EX -> MEM -> WB
      mem_lmask = 4'b0011; wb_we = 1; wb_dest = 5; wb_lmask = 4'b1111; wb_res = {4{32'hC}};
      tick();
      chk("fall_opa", opa_q, {32'hC, 32'hC, 32'hB, 32'hA});

      // r0 is never forwarded
      idle_inputs(); id_valid = 1; id_rs_a = 0;
      ex_alu(0, 4'b1111, {4{32'h11}});
      tick();
      chk("zero_opa", opa_q, {4{32'h0000_DEAD}});

      // immediate B against an EX load to the same address
      idle_inputs(); id_valid = 1; id_rs_a = 2; id_rs_b = 7; id_imm_b = 1;
      id_b_data = {4{32'h1234}};
      ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_dest = 7; ex_lmask = 4'b1111;
      #1 chk("imm_stall", VW'(stall_id), '0);
      tick();
      chk("imm_opb", opb_q, {4{32'h1234}});
      chk("imm_vld", VW'(op_valid_q), 1);

      // load-use with two wait cycles
      idle_inputs(); id_valid = 1; id_rs_a = 7;
      ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_dest = 7; ex_lmask = 4'b1111;
      #1 chk("lu_stall0", VW'(stall_id), 1);
      tick();
      chk("lu_vld0", VW'(op_valid_q), 0);
      ex_valid = 0; ex_we = 0; ex_is_load = 0;
      mem_valid = 1; mem_we = 1; mem_is_load = 1; mem_dest = 7; mem_lmask = 4'b1111; mem_rdy = 0;
      #1 chk("lu_stall1", VW'(stall_id), 1);
      tick();
      chk("lu_vld1", VW'(op_valid_q), 0);
      #1 chk("lu_stall2", VW'(stall_id), 1);
      tick();
      chk("lu_vld2", VW'(op_valid_q), 0);
      mem_rdy = 1; mem_res = {4{32'hCAFE}};
      #1 chk("lu_release", VW'(stall_id), 0);
      tick();
      chk("lu_opa", opa_q, {4{32'hCAFE}});
      chk("lu_vld", VW'(op_valid_q), 1);
      chk("lu_cnt", VW'(stall_cnt), 3);

      // counter saturation under a MEM-load stall, then clear while stalled
      idle_inputs(); id_valid = 1; id_rs_a = 7;
      mem_valid = 1; mem_we = 1; mem_is_load = 1; mem_dest = 7; mem_lmask = 4'b0100; mem_rdy = 0;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_cnt", VW'(stall_cnt), 15);
      cnt_clr = 1;
      tick();
      chk("clr_cnt", VW'(stall_cnt), 0);
      cnt_clr = 0;
      tick();
      chk("clr_cnt_inc", VW'(stall_cnt), 1);

      // reset while waiting on a load
      idle_inputs(); id_valid = 1; id_rs_a = 7;
      ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_dest = 7; ex_lmask = 4'b1111;
      tick();
      ex_valid = 0; ex_we = 0; ex_is_load = 0;
      mem_valid = 1; mem_we = 1; mem_is_load = 1; mem_dest = 7; mem_lmask = 4'b1111; mem_rdy = 0;
      rst = 1;
      #1 chk("rstw_stall", VW'(stall_id), 0);
      tick();
      chk("rstw_vld", VW'(op_valid_q), 0);
      chk("rstw_cnt", VW'(stall_cnt), 0);
      chk("rstw_opa", opa_q, '0);
      rst = 0;
      mem_valid = 0; mem_we = 0; mem_is_load = 0;
      #1 chk("rstw_run_stall", VW'(stall_id), 0);
      tick();
      chk("rstw_run_vld", VW'(op_valid_q), 1);

      idle_inputs();
      tick(); tick();
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vec_fwd_hazard_unit.md
Name: vec_fwd_hazard_unit

Overview:
- Parametrised successor to the scalar operand-forwarding mux pair in the ASIP pipeline.
- Resolves both source operands of the instruction in ID against the EX, MEM and WB destinations, with per-lane masking for vector registers.
- Detects load-use hazards and holds ID while a load result is outstanding, with a variable-latency memory handshake.
- Registers the resolved operands into the ID/EX operand latch and keeps a saturating stall counter for profiling.

Parameters:
LANES, 4, number of vector lanes per register
LANE_W, 32, bits per lane
RADDR_W, 4, register-address width; address 0 is the hard-wired zero register
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_a  in  RADDR_W  source A register
id_rs_b  in  RADDR_W  source B register
id_imm_b  in  1  B is an immediate: no forwarding and no hazard on B
id_a_data  in  LANES*LANE_W  register-file read A
id_b_data  in  LANES*LANE_W  register-file read B, or the immediate when id_imm_b=1
ex_valid, ex_we, ex_is_load  in  1 each  EX-stage qualifiers
ex_dest  in  RADDR_W  EX destination
ex_lmask  in  LANES  EX lane write mask
ex_res  in  LANES*LANE_W  ALU result in EX
mem_valid, mem_we, mem_is_load, mem_rdy  in  1 each  MEM qualifiers; mem_rdy=1 means MEM data is valid this cycle
mem_dest  in  RADDR_W  MEM destination
mem_lmask  in  LANES  MEM lane write mask
mem_res  in  LANES*LANE_W  MEM-stage result or load data
wb_we  in  1  WB write enable
wb_dest  in  RADDR_W  WB destination
wb_lmask  in  LANES  WB lane write mask
wb_res  in  LANES*LANE_W  WB result
cnt_clr  in  1  clear stall counter
stall_id  out  1  hold PC and IF/ID; combinational
opa_q, opb_q  out  LANES*LANE_W  latched operands for EX
op_valid_q  out  1  latched instruction valid; 0 means bubble
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: opa_q=0, opb_q=0, op_valid_q=0, stall_cnt=0, FSM=RUN. stall_id=0 during rst.
- Per-lane forward select, for source s and lane l. Candidates in priority order:
  - EX, when ex_valid & ex_we & ~ex_is_load & ex_dest==s & ex_lmask[l].
  - MEM, when mem_valid & mem_we & mem_dest==s & mem_lmask[l] & (~mem_is_load | mem_rdy).
  - WB, when wb_we & wb_dest==s & wb_lmask[l].
  - Otherwise the register-file lane.
- s==0 never forwards and yields the register-file value.
- Lanes are independent: a lane not written by EX falls through to MEM, then WB, then the register file.
- B is never forwarded and never hazards when id_imm_b=1.
- Hazard terms:
  - hz_ex: id_valid & any used source matches an EX load (ex_valid & ex_we & ex_is_load) with a nonzero overlapping lane in ex_lmask.
  - hz_mem: the same match against a MEM load with mem_rdy=0.
- FSM:
  - RUN: stall_id = hz_ex | hz_mem. Go to LU_WAIT if hz_ex, else stay in RUN.
  - LU_WAIT: the load is now in MEM. stall_id = ~mem_rdy. Stay while mem_rdy=0; return to RUN on mem_rdy=1, in the same cycle forwarding mem_res and releasing the stall.
- Operand latch, every edge:
  - If stall_id=1: op_valid_q←0 (bubble); opa_q and opb_q hold.
  - Else: opa_q/opb_q ← resolved operands; op_valid_q ← id_valid.
- Counter: stall_cnt increments on every stall_id=1 cycle and saturates at all-ones. cnt_clr clears it; cnt_clr wins over increment in the same cycle.
- rst asserted mid-stall: FSM→RUN and all outputs return to reset values on the next edge. Outstanding-load tracking is discarded.
- Latency: the resolved operand appears on opa_q/opb_q one cycle after ID presents it unstalled.

Test Plan:
- No hazard: rs_a=3, ex_dest=3, ex_res lanes=0x11, full mask -> next cycle opa_q lanes=0x11, stall_id=0.
- Priority and lane masking: rs_a=5, ex_lmask=0b0001 with ex_res=0xA, mem_lmask=0b1111 with mem_res=0xB -> opa_q lanes = {B,B,B,A} (lane 3 down to lane 0).
- Zero register and immediate: rs_a=0 with ex_dest=0 and ex_we=1 -> register-file value used. id_imm_b=1, rs_b=ex_dest=load -> no stall, opb_q=id_b_data.
- Load-use with memory wait: EX load to r7 while ID reads r7; mem_rdy low for 2 cycles then high with mem_res=0xCAFE -> stall_id high for 3 cycles, op_valid_q=0 for 3 cycles, then opa_q=0xCAFE with op_valid_q=1, stall_cnt=3.
- Counter saturation and clear: with CNT_W=4, hold a stall for 20 cycles -> stall_cnt=15. Assert cnt_clr during a stall -> stall_cnt=0 on the next edge.
- Reset during LU_WAIT: rst=1 for 1 cycle -> FSM=RUN, stall_id=0, op_valid_q=0, stall_cnt=0.
